// File: rtl/n2t_pkg.sv
// -----------------------------------------------------------------------------
// n2t_pkg
// Shared constants and types for the Hack-style memory hierarchy
// (ram8_16 -> ram64_16 -> ram512/ram4k).
//   WORD_W   : data word width
//   word_t   : one data word
//   RAM8_AW  : address bits inside one 8-word bank
//   RAM64_AW : address bits of the 64-word memory
// -----------------------------------------------------------------------------
package n2t_pkg;

    localparam int WORD_W   = 16;
    typedef logic [WORD_W-1:0] word_t;

    localparam int RAM8_AW  = 3;
    localparam int RAM64_AW = 6;

endpackage : n2t_pkg

// File: rtl/ram8_16.sv
// -----------------------------------------------------------------------------
// ram8_16
// Eight words of WIDTH-bit storage, each a register with a load mux.
// Asynchronous active-low reset clears every word; read is combinational.
// Ports:
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset (clears all words)
//   in      : write data
//   load    : write enable, sampled on rising clk
//   address : word select within the bank
//   out     : data of the word at address (combinational)
// -----------------------------------------------------------------------------
module ram8_16
    import n2t_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   in,
    input  logic               load,
    input  logic [RAM8_AW-1:0] address,
    output logic [WIDTH-1:0]   out
);

    localparam int DEPTH = 1 << RAM8_AW;

    logic [WIDTH-1:0] rd_word [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_word
            logic [WIDTH-1:0] word_q;
            logic [WIDTH-1:0] word_d;

            // Only the addressed word takes the new data; the rest recirculate.
            always_comb begin
                word_d = word_q;
                if (load && (address == RAM8_AW'(gi))) begin
                    word_d = in;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    word_q <= '0;
                end else begin
                    word_q <= word_d;
                end
            end

            assign rd_word[gi] = word_q;
        end
    endgenerate

    assign out = rd_word[address];

endmodule : ram8_16

// File: rtl/ram64_16.sv
// -----------------------------------------------------------------------------
// ram64_16
// 64-word x WIDTH-bit read/write memory built from eight ram8_16 banks.
// address[5:3] picks the bank (decoded into per-bank load, muxed on read),
// address[2:0] picks the word within the bank.
// Ports:
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset (clears all 64 words)
//   in      : write data
//   load    : write enable, sampled on rising clk
//   address : 6-bit word select
//   out     : read data of the word at address
// Build option:
//   RAM64_OUT_REG_EN : when defined, out is registered (1-cycle read latency,
//                      async reset to 0); otherwise out is combinational.
// -----------------------------------------------------------------------------
module ram64_16
    import n2t_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int BANKS = 8         // tied to the 3+3 address split
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [WIDTH-1:0]    in,
    input  logic                load,
    input  logic [RAM64_AW-1:0] address,
    output logic [WIDTH-1:0]    out
);

    localparam int BSEL_W = RAM64_AW - RAM8_AW;

    logic [BSEL_W-1:0]  bank_sel;
    logic [RAM8_AW-1:0] word_sel;
    logic [BANKS-1:0]   bank_load;
    logic [WIDTH-1:0]   bank_out [BANKS];
    logic [WIDTH-1:0]   rd_data;

    assign bank_sel = address[RAM64_AW-1:RAM8_AW];
    assign word_sel = address[RAM8_AW-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < BANKS; gi++) begin : g_bank
            // DMux8Way: load reaches only the selected bank.
            assign bank_load[gi] = load && (bank_sel == BSEL_W'(gi));

            ram8_16 #(
                .WIDTH   (WIDTH)
            ) u_ram8 (
                .clk     (clk),
                .rst_n   (rst_n),
                .in      (in),
                .load    (bank_load[gi]),
                .address (word_sel),
                .out     (bank_out[gi])
            );
        end
    endgenerate

    // Mux8Way16: pick the selected bank's output.
    assign rd_data = bank_out[bank_sel];

`ifdef RAM64_OUT_REG_EN
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;

    // Captures pre-edge storage contents, so a same-address write shows
    // the old word first and the new word one cycle later.
    always_comb begin
        out_d = rd_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;
`else
    assign out = rd_data;
`endif

endmodule : ram64_16
